// File: rtl/gpr_sb_pkg.sv
// Shared constants for the GPR file / scoreboard.
// GPR_ZERO_REG_EN: when defined, register 0 is hardwired to zero.
package gpr_sb_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned NUM_REGS_DEF = 32;

  // Active-low strobe levels and reset assertion level
  localparam logic ENABLE_      = 1'b0;
  localparam logic DISABLE_     = 1'b1;
  localparam logic RESET_ENABLE = 1'b0;

`ifdef GPR_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  // First register that holds real state
  localparam int FIRST_REG = ZERO_REG_EN ? 1 : 0;

endpackage

// File: rtl/gpr_sb_rdport.sv
// One read port: write-to-read bypass mux plus scoreboard busy flag.
module gpr_sb_rdport
  import gpr_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              active,
  input  logic [ADDR_W-1:0] addr,
  input  logic              in_range,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              pend_bit,
  input  logic              we0_,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1_,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic is_zero;
  logic hit0;
  logic hit1;

  assign is_zero = ZERO_REG_EN && (addr == '0);
  assign hit0    = (we0_ == ENABLE_) && (waddr0 == addr) && in_range && !is_zero;
  assign hit1    = (we1_ == ENABLE_) && (waddr1 == addr) && in_range && !is_zero;

  // Port 1 result has priority, matching the storage write order
  always_comb begin
    rd_data = reg_val;
    if (!active || is_zero || !in_range) rd_data = '0;
    else if (hit1)                       rd_data = wdata1;
    else if (hit0)                       rd_data = wdata0;
  end

  // A result landing this cycle is forwarded, so it does not stall
  assign rd_busy = active && pend_bit && !(hit0 || hit1);

endmodule

// File: rtl/gpr_sb.sv
// Register file with two write ports, NUM_RD bypassed read ports and a pending-bit scoreboard.
// Honors GPR_ZERO_REG_EN (via gpr_sb_pkg) to hardwire register 0.
module gpr_sb
  import gpr_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0_,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1_,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     iss_,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush_,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_next;
  logic [NUM_REGS-1:0] wr0_hit;
  logic [NUM_REGS-1:0] wr1_hit;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_next;

  // Per-register write decode; out-of-range addresses match nothing
  always_comb begin
    wr0_hit = '0;
    wr1_hit = '0;
    for (int r = FIRST_REG; r < int'(NUM_REGS); r++) begin
      wr0_hit[r] = (we0_ == ENABLE_) && (waddr0 == ADDR_W'(r));
      wr1_hit[r] = (we1_ == ENABLE_) && (waddr1 == ADDR_W'(r));
    end
  end

  // Scoreboard next state: flush > issue > writeback clear > hold
  always_comb begin
    pend_next = pend_q;
    cnt_next  = '0;
    for (int r = FIRST_REG; r < int'(NUM_REGS); r++) begin
      if (flush_ == ENABLE_)                               pend_next[r] = 1'b0;
      else if (iss_ == ENABLE_ && iss_addr == ADDR_W'(r))  pend_next[r] = 1'b1;
      else if (wr0_hit[r] || wr1_hit[r])                   pend_next[r] = 1'b0;
    end
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      cnt_next = cnt_next + CNT_W'(pend_next[r]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      for (int r = 0; r < int'(NUM_REGS); r++) regs_q[r] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = FIRST_REG; r < int'(NUM_REGS); r++) begin
        if (wr1_hit[r])      regs_q[r] <= wdata1;
        else if (wr0_hit[r]) regs_q[r] <= wdata0;
      end
      pend_q <= pend_next;
      cnt_q  <= cnt_next;
    end
  end

  assign pend_cnt = cnt_q;

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              in_range;
    logic [DATA_W-1:0] reg_val;
    logic              pend_bit;

    assign addr     = rd_addr[k*ADDR_W +: ADDR_W];
    assign in_range = 32'(addr) < NUM_REGS;
    assign reg_val  = in_range ? regs_q[addr] : '0;
    assign pend_bit = in_range && pend_q[addr];

    gpr_sb_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .active   (reset != RESET_ENABLE),
      .addr     (addr),
      .in_range (in_range),
      .reg_val  (reg_val),
      .pend_bit (pend_bit),
      .we0_     (we0_),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .we1_     (we1_),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
      .rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_gpr_sb.sv
// Directed, table-driven bench for gpr_sb (24 registers so out-of-range addresses are reachable).
module tb_gpr_sb;

`ifdef GPR_ZERO_REG_EN
  localparam bit ZE = 1'b1;
`else
  localparam bit ZE = 1'b0;
`endif

  localparam int NREG = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic        we0_, we1_, iss_, flush_;
  logic [4:0]  waddr0, waddr1, iss_addr;
  logic [31:0] wdata0, wdata1;
  logic [5:0]  pend_cnt;

  int errors = 0;
  int checks = 0;

  gpr_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(NREG), .NUM_RD(3)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0_(we0_), .waddr0(waddr0), .wdata0(wdata0), .we1_(we1_), .waddr1(waddr1),
    .wdata1(wdata1), .iss_(iss_), .iss_addr(iss_addr), .flush_(flush_), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we0_;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1_;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic        iss_;
    logic [4:0]  iss_addr;
    logic        flush_;
    logic [4:0]  ra [3];
    logic [31:0] ed [3];
    logic [2:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  function automatic vec_t mk(int w0, int a0, int d0, int w1, int a1, int d1,
                              int is, int ia, int fl, int r0, int r1, int r2,
                              int e0, int e1, int e2, int eb, int ec);
    vec_t v;
    v.we0_ = 1'(w0); v.waddr0 = 5'(a0); v.wdata0 = 32'(d0);
    v.we1_ = 1'(w1); v.waddr1 = 5'(a1); v.wdata1 = 32'(d1);
    v.iss_ = 1'(is); v.iss_addr = 5'(ia); v.flush_ = 1'(fl);
    v.ra[0] = 5'(r0); v.ra[1] = 5'(r1); v.ra[2] = 5'(r2);
    v.ed[0] = 32'(e0); v.ed[1] = 32'(e1); v.ed[2] = 32'(e2);
    v.eb = 3'(eb); v.ec = 6'(ec);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    we0_ = 1'b1; we1_ = 1'b1; iss_ = 1'b1; flush_ = 1'b1;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_addr = '0;
  endtask

  task automatic check_all(input string nm, input int idx, input vec_t v);
    for (int k = 0; k < 3; k++) chk({nm, "_data"}, idx * 4 + k, rd_data[k*32 +: 32], v.ed[k]);
    chk({nm, "_busy"}, idx, 32'(rd_busy), 32'(v.eb));
    chk({nm, "_cnt"}, idx, 32'(pend_cnt), 32'(v.ec));
  endtask

  vec_t tbl [$];

  initial begin
    int z0, z1;
    idle();
    rd_addr = '0;
    reset = 1'b0;

    // Vector columns: we0_,waddr0,wdata0, we1_,waddr1,wdata1, iss_,iss_addr, flush_,
    //                 rd_addr x3, expected rd_data x3, expected busy {p2,p1,p0}, expected pend_cnt
    tbl.push_back(mk(1,0,0,       1,0,0,       1,0, 1, 0,1,31, 0,0,0,                     0,0));
    tbl.push_back(mk(0,5,'h1111,  0,5,'h2222,  1,0, 1, 5,5,6,  'h2222,'h2222,0,           0,0));
    tbl.push_back(mk(1,0,0,       1,0,0,       1,0, 1, 5,0,6,  'h2222,0,0,                0,0));
    tbl.push_back(mk(1,0,0,       1,0,0,       0,7, 1, 7,5,0,  0,'h2222,0,                0,0));
    tbl.push_back(mk(1,0,0,       1,0,0,       1,0, 1, 7,5,7,  0,'h2222,0,                5,1));
    tbl.push_back(mk(0,7,'hABCD,  1,0,0,       1,0, 1, 7,7,5,  'hABCD,'hABCD,'h2222,      0,1));
    tbl.push_back(mk(1,0,0,       1,0,0,       1,0, 1, 7,5,0,  'hABCD,'h2222,0,           0,0));
    tbl.push_back(mk(1,0,0,       0,3,'h3333,  0,3, 1, 3,7,0,  'h3333,'hABCD,0,           0,0));
    tbl.push_back(mk(1,0,0,       1,0,0,       1,0, 1, 3,0,0,  'h3333,0,0,                1,1));
    tbl.push_back(mk(0,3,'h4444,  1,0,0,       0,1, 1, 3,1,0,  'h4444,0,0,                0,1));
    tbl.push_back(mk(1,0,0,       1,0,0,       0,2, 1, 1,2,3,  0,0,'h4444,                1,1));
    tbl.push_back(mk(1,0,0,       1,0,0,       0,4, 1, 1,2,4,  0,0,0,                     3,2));
    tbl.push_back(mk(1,0,0,       1,0,0,       0,6, 0, 1,2,4,  0,0,0,                     7,3));
    tbl.push_back(mk(1,0,0,       1,0,0,       1,0, 1, 1,2,6,  0,0,0,                     0,0));
    tbl.push_back(mk(1,0,0,       1,0,0,       0,9, 1, 9,6,0,  0,0,0,                     0,0));
    tbl.push_back(mk(1,0,0,       1,0,0,       0,9, 1, 9,6,0,  0,0,0,                     1,1));
    tbl.push_back(mk(1,0,0,       1,0,0,       1,0, 1, 9,6,0,  0,0,0,                     1,1));
    tbl.push_back(mk(0,30,'h5555, 0,23,'h7777, 0,30,1, 30,23,31, 0,'h7777,0,              0,1));
    tbl.push_back(mk(1,0,0,       1,0,0,       1,0, 1, 23,30,9, 'h7777,0,0,               4,1));
    tbl.push_back(mk(1,0,0,       0,9,'h9999,  1,0, 1, 9,23,0, 'h9999,'h7777,0,           0,1));
    z0 = ZE ? 0 : 'hFFFF;
    tbl.push_back(mk(0,0,'hFFFF,  1,0,0,       0,0, 1, 0,9,0,  z0,'h9999,z0,              0,0));
    tbl.push_back(mk(1,0,0,       1,0,0,       1,0, 1, 0,9,0,  z0,'h9999,z0,              ZE ? 0 : 5, ZE ? 0 : 1));
    z1 = ZE ? 0 : 'h5678;
    tbl.push_back(mk(0,0,'h1234,  0,0,'h5678,  1,0, 1, 0,0,9,  z1,z1,'h9999,              0, ZE ? 0 : 1));

    // Outputs while reset is held, even with a write bypass pending
    #2;
    we0_ = 1'b0; waddr0 = 5'd5; wdata0 = 32'hDEAD; rd_addr = {5'd5, 5'd5, 5'd5};
    #1;
    chk("rst_data", 0, rd_data[31:0], 32'h0);
    chk("rst_busy", 0, 32'(rd_busy), 32'h0);
    chk("rst_cnt", 0, 32'(pend_cnt), 32'h0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      we0_ = tbl[i].we0_; waddr0 = tbl[i].waddr0; wdata0 = tbl[i].wdata0;
      we1_ = tbl[i].we1_; waddr1 = tbl[i].waddr1; wdata1 = tbl[i].wdata1;
      iss_ = tbl[i].iss_; iss_addr = tbl[i].iss_addr; flush_ = tbl[i].flush_;
      rd_addr = {tbl[i].ra[2], tbl[i].ra[1], tbl[i].ra[0]};
      #1;
      check_all("vec", i, tbl[i]);
    end

    // Fill the scoreboard: flush, then issue every register once
    @(negedge clk); idle(); flush_ = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      @(negedge clk); idle(); iss_ = 1'b0; iss_addr = 5'(r);
    end
    @(negedge clk); idle(); rd_addr = {5'd0, 5'd12, 5'd23};
    #1;
    chk("full_cnt", 0, 32'(pend_cnt), ZE ? 32'd23 : 32'd24);
    chk("full_busy", 0, 32'(rd_busy), ZE ? 32'h3 : 32'h7);
    flush_ = 1'b0;
    @(negedge clk); idle();
    #1;
    chk("full_flush_cnt", 0, 32'(pend_cnt), 32'd0);
    chk("full_flush_busy", 0, 32'(rd_busy), 32'h0);

    // Asynchronous reset mid-cycle discards in-flight write and issue
    @(negedge clk);
    we0_ = 1'b0; waddr0 = 5'd10; wdata0 = 32'hAAAA; iss_ = 1'b0; iss_addr = 5'd10;
    rd_addr = {5'd0, 5'd5, 5'd10};
    #1;
    chk("mid_bypass", 0, rd_data[31:0], 32'hAAAA);
    chk("mid_pre_r5", 0, rd_data[63:32], 32'h2222);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_data", 0, rd_data[31:0], 32'h0);
    chk("mid_rst_r5", 0, rd_data[63:32], 32'h0);
    chk("mid_rst_cnt", 0, 32'(pend_cnt), 32'h0);
    @(negedge clk); reset = 1'b1; idle();
    #1;
    chk("post_rst_r10", 0, rd_data[31:0], 32'h0);
    chk("post_rst_busy", 0, 32'(rd_busy), 32'h0);
    @(negedge clk);
    #1;
    chk("post_rst_cnt", 0, 32'(pend_cnt), 32'h0);
    chk("post_rst_busy", 1, 32'(rd_busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
